btb: RTL and testbench

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
- Target writes: sent by the decode stage when it decodes JAL or a conditional branch.
- Direction training: resolved outcomes come from the execute stage.
- Prediction: same-cycle taken/target for the fetch PC, used by the IF stage for next-PC selection.

---
 rtl/btb.sv | 93 +++++++++
 tb/tb_btb.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Same-cycle lookup from registered state; decode writes targets, execute trains direction.
module btb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_waddr_i,
  input  logic [ADDR_W-1:0] b_wtarget_i,
  input  logic              ex_upd_i,
  input  logic [ADDR_W-1:0] ex_upd_pc_i,
  input  logic              ex_taken_i,
  output logic              hit_o
);

  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;
  localparam int unsigned ENTRIES = 1 << INDEX_W;

  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  logic [INDEX_W-1:0] l_idx, w_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, w_tag, u_tag;
  logic               l_hit, w_hit, u_hit;
  logic               w_en, w_alloc, u_en;
  logic [1:0]         u_ctr, u_ctr_next;
  logic               unused_lsb;

  assign l_idx = if_pc_i[INDEX_W+1:2];
  assign l_tag = if_pc_i[ADDR_W-1:INDEX_W+2];
  assign w_idx = b_waddr_i[INDEX_W+1:2];
  assign w_tag = b_waddr_i[ADDR_W-1:INDEX_W+2];
  assign u_idx = ex_upd_pc_i[INDEX_W+1:2];
  assign u_tag = ex_upd_pc_i[ADDR_W-1:INDEX_W+2];

  assign unused_lsb = ^{b_waddr_i[1:0], ex_upd_pc_i[1:0]};

  // Lookup: combinational from pre-edge state, forced to a miss while in reset
  assign l_hit         = rst_n & valid_q[l_idx] & (tag_q[l_idx] == l_tag);
  assign hit_o         = l_hit;
  assign pred_taken_o  = l_hit & ctr_q[l_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[l_idx] : if_pc_i + ADDR_W'(4);

  assign w_hit   = valid_q[w_idx] & (tag_q[w_idx] == w_tag);
  assign u_hit   = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign w_en    = rdy & b_we_i;
  assign w_alloc = w_en & ~w_hit;
  assign u_en    = rdy & ex_upd_i & u_hit;

  // Saturating counter step from the pre-edge value
  always_comb begin
    u_ctr      = ctr_q[u_idx];
    u_ctr_next = u_ctr;
    if (ex_taken_i) begin
      if (u_ctr != 2'b11) u_ctr_next = u_ctr + 2'b01;
    end else begin
      if (u_ctr != 2'b00) u_ctr_next = u_ctr - 2'b01;
    end
  end

  // Valid/counter state; allocation is written last so it overrides an update to the same entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      if (u_en) ctr_q[u_idx] <= u_ctr_next;
      if (w_alloc) begin
        valid_q[w_idx] <= 1'b1;
        ctr_q[w_idx]   <= 2'b01;
      end
    end
  end

  // Tag and target arrays carry no reset; valid gates their use
  always_ff @(posedge clk) begin
    if (w_en) begin
      tag_q[w_idx]    <= w_tag;
      target_q[w_idx] <= b_wtarget_i;
    end
  end

endmodule

// File: tb/tb_btb.sv
// Directed self-checking bench for btb: allocation, training, aliasing,
// same-cycle write/update, rdy gating, async reset and PC wrap.
module tb_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        b_we;
  logic [31:0] b_waddr;
  logic [31:0] b_wtarget;
  logic        ex_upd;
  logic [31:0] ex_upd_pc;
  logic        ex_taken;
  logic        hit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .if_pc_i      (if_pc),
    .pred_taken_o (pred_taken),
    .pred_target_o(pred_target),
    .b_we_i       (b_we),
    .b_waddr_i    (b_waddr),
    .b_wtarget_i  (b_wtarget),
    .ex_upd_i     (ex_upd),
    .ex_upd_pc_i  (ex_upd_pc),
    .ex_taken_i   (ex_taken),
    .hit_o        (hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    b_we   = 1'b0;
    ex_upd = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] t);
    b_we = 1'b1; b_waddr = a; b_wtarget = t;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk);
    ex_upd = 1'b1; ex_upd_pc = pc; ex_taken = tk;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic eh,
                      input logic et, input logic [31:0] etgt);
    look(pc);
    chk({tag, ".hit"}, 32'(hit), 32'(eh));
    chk({tag, ".taken"}, 32'(pred_taken), 32'(et));
    chk({tag, ".target"}, pred_target, etgt);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; if_pc = 32'h0;
    b_we = 1'b0; b_waddr = 32'h0; b_wtarget = 32'h0;
    ex_upd = 1'b0; ex_upd_pc = 32'h0; ex_taken = 1'b0;

    pred("in_reset", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
    #12 rst_n = 1'b1;
    tick();

    // 1. empty after reset
    pred("t1", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);

    // 2. allocate and train
    wr(32'h0000_1000, 32'h0000_0800);
    pred("t2.pre_alloc", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
    tick();
    pred("t2.alloc", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);
    upd(32'h0000_1000, 1'b1); tick();
    pred("t2.t1", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0800);
    for (int i = 0; i < 3; i++) begin upd(32'h0000_1000, 1'b1); tick(); end
    upd(32'h0000_1000, 1'b0); tick();
    pred("t2.sat_nt", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0800);
    upd(32'h0000_1000, 1'b0); tick();
    pred("t2.nt2", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);

    // 3. alias replacement (ctr 01 -> 11 first)
    for (int i = 0; i < 2; i++) begin upd(32'h0000_1000, 1'b1); tick(); end
    pred("t3.trained", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0800);
    wr(32'h0000_1100, 32'h0000_0A00); tick();
    pred("t3.old_miss", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
    pred("t3.new_hit", 32'h0000_1100, 1'b1, 1'b0, 32'h0000_1104);
    for (int i = 0; i < 2; i++) begin upd(32'h0000_1000, 1'b1); tick(); end
    pred("t3.alias_ign", 32'h0000_1100, 1'b1, 1'b0, 32'h0000_1104);
    upd(32'h0000_1100, 1'b1); tick();
    pred("t3.own_upd", 32'h0000_1100, 1'b1, 1'b1, 32'h0000_0A00);

    // 4. same-cycle write hit and taken update (ctr 10 -> 11, target replaced)
    wr(32'h0000_1000, 32'h0000_0800); tick();
    upd(32'h0000_1000, 1'b1); tick();
    wr(32'h0000_1000, 32'h0000_0900);
    upd(32'h0000_1000, 1'b1);
    pred("t4.no_bypass", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0800);
    tick();
    pred("t4.after", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0900);
    upd(32'h0000_1000, 1'b0); tick();
    pred("t4.was11", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0900);
    upd(32'h0000_1000, 1'b0); tick();
    pred("t4.now01", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);

    // allocation beats an update to the old occupant; different entries proceed together
    for (int i = 0; i < 2; i++) begin upd(32'h0000_1000, 1'b1); tick(); end
    wr(32'h0000_1100, 32'h0000_0B00);
    upd(32'h0000_1000, 1'b1);
    tick();
    pred("t4.alloc_wins", 32'h0000_1100, 1'b1, 1'b0, 32'h0000_1104);
    wr(32'h0000_2004, 32'h0000_0C00);
    upd(32'h0000_1100, 1'b1);
    tick();
    pred("t4.par_upd", 32'h0000_1100, 1'b1, 1'b1, 32'h0000_0B00);
    pred("t4.par_wr", 32'h0000_2004, 1'b1, 1'b0, 32'h0000_2008);

    // 5. rdy low freezes state
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr(32'h0000_1100, 32'h0000_0D00);
      upd(32'h0000_1100, 1'b0);
      tick();
    end
    wr(32'h0000_3008, 32'h0000_0E00); tick();
    rdy = 1'b1;
    pred("t5.rdy_hold", 32'h0000_1100, 1'b1, 1'b1, 32'h0000_0B00);
    pred("t5.rdy_noalloc", 32'h0000_3008, 1'b0, 1'b0, 32'h0000_300C);

    // asynchronous reset mid-cycle
    look(32'h0000_1100);
    rst_n = 1'b0;
    pred("t5.rst_now", 32'h0000_1100, 1'b0, 1'b0, 32'h0000_1104);
    wr(32'h0000_1100, 32'h0000_0F00);
    tick();
    rst_n = 1'b1;
    pred("t5.post_rst_a", 32'h0000_1100, 1'b0, 1'b0, 32'h0000_1104);
    pred("t5.post_rst_b", 32'h0000_2004, 1'b0, 1'b0, 32'h0000_2008);
    wr(32'h0000_1100, 32'h0000_0F00); tick();
    upd(32'h0000_1100, 1'b1); tick();
    pred("t5.ctr_rst01", 32'h0000_1100, 1'b1, 1'b1, 32'h0000_0F00);

    // 6. wrap of fall-through PC
    pred("t6.wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
